// File: rtl/hadamard16_loader.sv
// hadamard16_loader: input stage of the 16-point Hadamard transform.
// Serial signed samples arrive on a valid/ready handshake. They are packed
// into the x0..x15 register bank. The bank is then frozen while start
// enables the downstream pipeline for PIPE_LAT clocks. After that,
// frame_done marks the cycle from which y0..y15 downstream are valid.
//
// Handshake: a sample is transferred on every rising edge where
// in_valid && in_ready. in_ready is a registered output and depends only on
// the loader's own state, never on in_valid. in_sof is meaningful only on a
// transferring edge.
module hadamard16_loader #(
    parameter int DW       = 9,
    parameter int NPT      = 16,
    parameter int PIPE_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] x0,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] x3,
    output logic [DW-1:0] x4,
    output logic [DW-1:0] x5,
    output logic [DW-1:0] x6,
    output logic [DW-1:0] x7,
    output logic [DW-1:0] x8,
    output logic [DW-1:0] x9,
    output logic [DW-1:0] x10,
    output logic [DW-1:0] x11,
    output logic [DW-1:0] x12,
    output logic [DW-1:0] x13,
    output logic [DW-1:0] x14,
    output logic [DW-1:0] x15,
    output logic          start,
    output logic          frame_done,
    output logic          sof_err,
    output logic [1:0]    fsm_state
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int LW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(PIPE_LAT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NPT - 1);

    logic [1:0]    state;
    logic [3:0]    idx;
    logic [LW-1:0] lat_cnt;
    logic [DW-1:0] bank [NPT];
    logic          accept;

    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    // Control path: FILL -> HOLD (start window) -> DONE (frame_done) -> FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= 4'd0;
            lat_cnt    <= '0;
            in_ready   <= 1'b1;
            start      <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            sof_err    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (in_sof) begin
                            // A fresh frame always restarts at slot 0; any
                            // partial frame in progress is dropped.
                            idx     <= 4'd1;
                            sof_err <= (idx != 4'd0);
                        end else if (idx == IDX_LAST) begin
                            idx      <= 4'd0;
                            lat_cnt  <= '0;
                            state    <= HOLD;
                            in_ready <= 1'b0;
                            start    <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (lat_cnt == LAT_LAST) begin
                        start      <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    in_ready <= 1'b1;
                    state    <= FILL;
                end
                default: begin
                    state    <= FILL;
                    idx      <= 4'd0;
                    in_ready <= 1'b1;
                    start    <= 1'b0;
                end
            endcase
        end
    end

    // Sample bank: written only on transfers during FILL, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPT; i++) begin
                bank[i] <= '0;
            end
        end else if (state == FILL && accept) begin
            if (in_sof) begin
                bank[0] <= in_data;
            end else begin
                bank[idx] <= in_data;
            end
        end
    end

    assign x0  = bank[0];
    assign x1  = bank[1];
    assign x2  = bank[2];
    assign x3  = bank[3];
    assign x4  = bank[4];
    assign x5  = bank[5];
    assign x6  = bank[6];
    assign x7  = bank[7];
    assign x8  = bank[8];
    assign x9  = bank[9];
    assign x10 = bank[10];
    assign x11 = bank[11];
    assign x12 = bank[12];
    assign x13 = bank[13];
    assign x14 = bank[14];
    assign x15 = bank[15];

endmodule

// File: doc/hadamard16_loader.md
Name: hadamard16_loader

Overview:
- Upstream input stage for the 16-point Hadamard transform.
- Accepts a serial stream of signed 9-bit samples with a valid/ready handshake and assembles 16 of them into a parallel register bank (x0..x15).
- Holds the bank stable while it asserts start for exactly PIPE_LAT cycles, so the 4-register-deep enable-gated transform pipeline produces a complete result.
- Then pulses frame_done, marking when the downstream y0..y15 are valid.

Parameters:
- DW, 9, sample width in bits (signed, two's complement).
- NPT, 16, samples per frame. Fixed at 16; the index counter is 4 bits.
- PIPE_LAT, 4, number of enabled clocks the downstream transform needs (two adder/subtractor stages × two 4-point levels).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a sample this cycle.
- in_sof  input  1  start-of-frame marker, qualified by in_valid.
- in_data  input  DW  signed sample.
- in_ready  output  1  loader can accept a sample this cycle.
- x0..x15  output  DW each  parallel frame to the transform; x0 is the first sample of the frame.
- start  output  1  enable to the transform pipeline.
- frame_done  output  1  one-cycle pulse; downstream y0..y15 are valid from this cycle.
- sof_err  output  1  one-cycle pulse; in_sof arrived with a partial frame pending.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - state=FILL, idx=0, lat_cnt=0.
  - x0..x15=0, start=0, frame_done=0, sof_err=0, in_ready=1.
  - Reset asserted mid-HOLD drops start immediately and discards the frame.
- A sample is accepted on any rising edge where in_valid && in_ready.
- FILL:
  - in_ready=1, start=0.
  - On accept, in_data is written to x[idx] and idx increments.
  - Accept with in_sof=1: sample goes to x0 and idx becomes 1. If idx!=0 at that moment, sof_err=1 for the next cycle and the partial frame is abandoned (already-written slots are overwritten later).
  - in_sof is not required; with no sof, frames simply run back-to-back modulo 16.
  - Accept at idx=15: idx wraps to 0, state moves to HOLD, and in the same edge in_ready goes to 0 and start to 1.
  - The accept at idx=15 is edge k.
- HOLD:
  - in_ready=0, start=1, x0..x15 frozen.
  - in_valid is ignored (no accept, no side effects).
  - lat_cnt counts 0..PIPE_LAT-1.
  - start is high for exactly PIPE_LAT sampled edges (k+1..k+PIPE_LAT).
  - At edge k+PIPE_LAT: start=0, frame_done=1, state=DONE.
- DONE:
  - One cycle; in_ready=0, start=0.
  - Next edge: frame_done=0, in_ready=1, state=FILL.
  - Downstream outputs remain valid while start stays 0, i.e. until the next frame completes filling.
- Throughput: 16 + PIPE_LAT + 1 cycles per frame with no input stalls.
- Arithmetic: none. Samples are stored bit-exact, including -256 and 255.
- Simultaneous events:
  - in_sof together with the 16th-slot condition is treated as sof (idx=1, sof_err if idx!=0). It never triggers HOLD.
  - sof_err and frame_done are never asserted together.

Test Plan:
- Basic frame:
  - Stimulus: 16 back-to-back accepts 1..16, sof on the first.
  - Required: x0..x15 = 1..16; start high exactly 4 cycles starting the cycle after the 16th accept; frame_done pulse on the 5th cycle after that accept; in_ready=0 for 5 cycles.
  - Required downstream: y0=136, y1=-8, y2=-16 (two's-complement 9-bit).
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly across 16 samples; in_valid held high during HOLD/DONE with changing data.
  - Required: only 16 samples captured; HOLD-period data is never written; x bank unchanged during start.
- Mid-frame sof:
  - Stimulus: accept 5 samples, then sof with value -7.
  - Required: sof_err pulses once; x0=-7; the frame completes after 15 more accepts; start begins after the 16th sample counted from the sof.
- Extremes:
  - Stimulus: samples alternating -256 / 255.
  - Required: stored bit-exact (9'h100 / 9'h0FF) in x0..x15.
- Reset mid-HOLD:
  - Stimulus: assert rst_n=0 during the 2nd start cycle.
  - Required: start=0 and in_ready=1 without waiting for a clock edge; x bank=0; no frame_done; the next 16 accepts produce a normal frame.
- Back-to-back frames:
  - Stimulus: 3 continuous frames.
  - Required: frame_done period is 21 cycles; each frame's x bank matches its input samples.
